store_unit: RTL and testbench

- Execute/memory stage directly downstream of the S-type instruction decoder.
- Consumes the decoded fields `imm_S_MSB`, `imm_S_LSB` and `funct3`, plus the register-file read data for rs1 and rs2.
- Computes the effective address, generates byte lanes for SB/SH/SW and drives a single-outstanding request/acknowledge write port to data memory.
- Flags misaligned or illegal stores instead of issuing them.

---
 rtl/store_pkg.sv | 23 ++
 rtl/store_align.sv | 42 ++++
 rtl/store_unit.sv | 124 ++++++++++++
 tb/tb_store_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared constants and types for the store unit: funct3 store widths,
// FSM state encoding and the byte-enable width.
package store_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned BE_W     = XLEN_DEF / 8;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    FAULT = 2'd3
  } state_t;

  function automatic logic is_legal_f3(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/store_align.sv
// Byte-lane steering for SB/SH/SW: byte enables, lane-shifted write data
// and the misalignment flag, all derived from the low address bits.
module store_align
  import store_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [1:0]        i_lane,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_rs2,
  output logic [XLEN/8-1:0] o_be,
  output logic [XLEN-1:0]   o_wdata,
  output logic              o_misalign
);

  localparam int unsigned BE = XLEN / 8;

  // NOTE: every output gets a default first, so no path leaves a latch behind.
  always_comb begin
    o_be       = '0;
    o_wdata    = '0;
    o_misalign = 1'b0;
    case (i_funct3)
      F3_SB: begin
        o_be    = BE'(1) << i_lane;
        o_wdata = XLEN'(i_rs2[7:0]) << {i_lane, 3'b000};
      end
      F3_SH: begin
        o_be       = BE'(3) << i_lane;
        o_wdata    = XLEN'(i_rs2[15:0]) << {i_lane, 3'b000};
        o_misalign = i_lane[0];
      end
      F3_SW: begin
        o_be       = '1;
        o_wdata    = i_rs2;
        o_misalign = |i_lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// S-type store execute stage: effective address, lane steering and a
// single-outstanding write port. Optional ack timeout under STORE_TIMEOUT_EN.
module store_unit
  import store_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        imm_S_MSB,
  input  logic [4:0]        imm_S_LSB,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_ack,
  output logic              done,
  output logic              misalign,
  output logic              illegal,
  output logic              bus_err
);

  state_t              r_state, w_next;
  logic [XLEN-1:0]     w_imm, w_ea, w_wdata;
  logic [XLEN/8-1:0]   w_be;
  logic                w_misalign, w_illegal, w_accept, w_expire;
  logic [XLEN-1:0]     r_addr, r_wdata;
  logic [XLEN/8-1:0]   r_be;
  logic                r_misalign, r_illegal;

  assign w_imm    = {{(XLEN-12){imm_S_MSB[6]}}, imm_S_MSB, imm_S_LSB};
  assign w_ea     = rs1_data + w_imm;
  assign w_illegal = !is_legal_f3(funct3);
  assign w_accept = (r_state == IDLE) && in_valid;

  store_align #(.XLEN(XLEN)) u_align (
    .i_lane     (w_ea[1:0]),
    .i_funct3   (funct3),
    .i_rs2      (rs2_data),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_misalign (w_misalign)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_misalign <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= {w_ea[XLEN-1:2], 2'b00};
      r_wdata    <= w_wdata;
      r_be       <= w_be;
      r_illegal  <= w_illegal;
      r_misalign <= !w_illegal && w_misalign;
    end
  end

`ifdef STORE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;

  assign w_expire = (r_state == REQ) && !mem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_accept)                       r_cnt <= '0;
      else if (r_state == REQ && !mem_ack) r_cnt <= r_cnt + CNT_W'(1);
      if (w_accept)      r_bus_err <= 1'b0;
      else if (w_expire) r_bus_err <= 1'b1;
    end
  end

  assign bus_err = (r_state == FAULT) && r_bus_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_expire         = 1'b0;
  assign bus_err          = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next = (w_illegal || w_misalign) ? FAULT : REQ;
      REQ: begin
        // Ack on the expiry cycle still completes the store.
        if (mem_ack)       w_next = RESP;
        else if (w_expire) w_next = FAULT;
      end
      RESP:    w_next = IDLE;
      FAULT:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE) && !rst;
  assign mem_req   = (r_state == REQ);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;
  assign done      = (r_state == RESP);
  assign misalign  = (r_state == FAULT) && r_misalign;
  assign illegal   = (r_state == FAULT) && r_illegal;

endmodule

// File: tb/tb_store_unit.sv
// Table-driven bench for store_unit with a scoreboard queue checked by a
// negedge monitor; the ack-timeout case runs when STORE_TIMEOUT_EN is defined.
module tb_store_unit;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;
`ifdef STORE_TIMEOUT_EN
  localparam int HOLD = 5;
`else
  localparam int HOLD = 24;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [6:0]        imm_S_MSB = '0;
  logic [4:0]        imm_S_LSB = '0;
  logic [2:0]        funct3 = '0;
  logic [XLEN-1:0]   rs1_data = '0;
  logic [XLEN-1:0]   rs2_data = '0;
  logic              mem_req;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic              mem_ack = 1'b0;
  logic              done, misalign, illegal, bus_err;

  always #5 clk = ~clk;

  store_unit #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .imm_S_MSB(imm_S_MSB), .imm_S_LSB(imm_S_LSB), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .done(done), .misalign(misalign),
    .illegal(illegal), .bus_err(bus_err)
  );

  typedef enum int {K_OK = 0, K_MIS = 1, K_ILL = 2, K_TO = 3} kind_e;
  typedef struct {
    logic [6:0]  msb;
    logic [4:0]  lsb;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          d;
    kind_e       kind;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } vec_t;

  vec_t sb_q[$];
  vec_t cur;
  vec_t vecs[12];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, t_acc = 0, ev_cnt = 0, req_cycles = 0;
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: pops on request start or fault pulse, checks on completion.
  always @(negedge clk) begin
    if (rst) begin
      prev_req   = 1'b0;
      req_cycles = 0;
    end else begin
      if (mem_req) begin
        if (!prev_req) begin
          if (sb_q.size() == 0) check("req_unexpected", 32'd1, 32'd0);
          else begin
            cur = sb_q.pop_front();
            check("req_kind", 32'(cur.kind == K_OK || cur.kind == K_TO), 32'd1);
            check("mem_addr", mem_addr, cur.addr);
            check("mem_be", 32'(mem_be), 32'(cur.be));
            check("mem_wdata", mem_wdata, cur.wdata);
          end
        end else begin
          check("addr_stable", mem_addr, cur.addr);
          check("be_stable", 32'(mem_be), 32'(cur.be));
          check("wdata_stable", mem_wdata, cur.wdata);
        end
        req_cycles++;
      end
      if (done) begin
        check("done_kind", 32'(cur.kind), 32'(K_OK));
        check("req_cycles", 32'(req_cycles), 32'(cur.d + 1));
        check("done_latency", 32'(cyc - t_acc), 32'(cur.d + 1));
        req_cycles = 0;
        ev_cnt++;
      end
      if (misalign || illegal) begin
        check("fault_exclusive", 32'(misalign && illegal), 32'd0);
        if (sb_q.size() == 0) check("fault_unexpected", 32'd1, 32'd0);
        else begin
          cur = sb_q.pop_front();
          check("fault_kind", 32'(cur.kind), misalign ? 32'(K_MIS) : 32'(K_ILL));
          check("fault_latency", 32'(cyc - t_acc), 32'd0);
        end
        ev_cnt++;
      end
      if (bus_err) begin
        check("bus_err_kind", 32'(cur.kind), 32'(K_TO));
        check("bus_err_req_cycles", 32'(req_cycles), 32'(TIMEOUT));
        check("bus_err_latency", 32'(cyc - t_acc), 32'(TIMEOUT));
        req_cycles = 0;
        ev_cnt++;
      end
      prev_req = mem_req;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    mem_ack = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    @(posedge clk); #1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    imm_S_MSB = v.msb;
    imm_S_LSB = v.lsb;
    funct3    = v.f3;
    rs1_data  = v.rs1;
    rs2_data  = v.rs2;
    sb_q.push_back(v);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    funct3    = 3'b111;
    rs1_data  = $urandom;
    rs2_data  = $urandom;
    t_acc     = cyc;
  endtask

  task automatic run_vec(input vec_t v);
    int  start;
    bit  got;
    drive(v);
    start = ev_cnt;
    if (v.kind == K_OK) begin
      repeat (v.d) begin @(posedge clk); #1; end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      if (ev_cnt != start) got = 1'b1;
    end
    check("event_seen", 32'(got), 32'd1);
    if (!got) do_reset();
    else begin
      @(negedge clk);
      check("in_ready_after", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    vec_t v;
    vecs[0]  = '{7'b0000111, 5'b11101, 3'b000, 32'h0000_1000, 32'h0000_00A5, 0, K_OK,  32'h0000_10FC, 4'b0010, 32'h0000_A500};
    vecs[1]  = '{7'b0000111, 5'b11101, 3'b010, 32'h0000_1000, 32'h1111_2222, 0, K_MIS, 32'h0, 4'h0, 32'h0};
    vecs[2]  = '{7'b1000100, 5'b00001, 3'b010, 32'h0000_207F, 32'hDEAD_BEEF, 1, K_OK,  32'h0000_1900, 4'b1111, 32'hDEAD_BEEF};
    vecs[3]  = '{7'b0000000, 5'b00000, 3'b001, 32'h0000_3002, 32'h0000_1234, 3, K_OK,  32'h0000_3000, 4'b1100, 32'h1234_0000};
    vecs[4]  = '{7'b0000111, 5'b11101, 3'b011, 32'h0000_1000, 32'h0000_0001, 0, K_ILL, 32'h0, 4'h0, 32'h0};
    vecs[5]  = '{7'b0000000, 5'b00000, 3'b001, 32'h0000_3001, 32'h0000_5678, 0, K_MIS, 32'h0, 4'h0, 32'h0};
    vecs[6]  = '{7'b0000000, 5'b00000, 3'b000, 32'h0000_0043, 32'hFFFF_FF77, 0, K_OK,  32'h0000_0040, 4'b1000, 32'h7700_0000};
    vecs[7]  = '{7'b0000000, 5'b01000, 3'b010, 32'hFFFF_FFFC, 32'h0123_4567, 2, K_OK,  32'h0000_0004, 4'b1111, 32'h0123_4567};
    vecs[8]  = '{7'b1111111, 5'b11110, 3'b001, 32'h0000_0102, 32'hCAFE_BEEF, 0, K_OK,  32'h0000_0100, 4'b0011, 32'h0000_BEEF};
    vecs[9]  = '{7'b0000000, 5'b00000, 3'b111, 32'h0000_0200, 32'h0000_0000, 0, K_ILL, 32'h0, 4'h0, 32'h0};
    vecs[10] = '{7'b0000000, 5'b00000, 3'b000, 32'h0000_0200, 32'h1234_56AB, 0, K_OK,  32'h0000_0200, 4'b0001, 32'h0000_00AB};
    vecs[11] = '{7'b0000000, 5'b00000, 3'b100, 32'h0000_0300, 32'h0000_0000, 0, K_ILL, 32'h0, 4'h0, 32'h0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ready_after_release", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Ack while idle must not produce a completion.
    start = ev_cnt;
    @(posedge clk); #1;
    mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("idle_ack_no_req", 32'(mem_req), 32'd0);
    @(posedge clk);
    check("idle_ack_ignored", 32'(ev_cnt), 32'(start));

    // Reset mid-request: mem_req drops at once and no done follows.
    v = '{7'b0000000, 5'b00000, 3'b010, 32'h0000_0800, 32'hA5A5_5A5A, 0, K_OK, 32'h0000_0800, 4'b1111, 32'hA5A5_5A5A};
    drive(v);
    start = ev_cnt;
    repeat (HOLD) @(posedge clk);
    #3;
    check("req_held_no_ack", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_drops_req", 32'(mem_req), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    check("rst_mid_be", 32'(mem_be), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ready_after_mid_rst", 32'(in_ready), 32'd1);
    repeat (4) @(posedge clk);
    check("no_done_after_rst", 32'(ev_cnt), 32'(start));
    check("no_req_after_rst", 32'(mem_req), 32'd0);

`ifdef STORE_TIMEOUT_EN
    // Ack never arrives: bus_err after TIMEOUT request cycles.
    v = '{7'b0000000, 5'b00000, 3'b010, 32'h0000_0500, 32'h0000_0055, 0, K_TO, 32'h0000_0500, 4'b1111, 32'h0000_0055};
    run_vec(v);
`endif

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
